// File: rtl/nf_chi_compress.sv
// Glitch-barrier register, share-wise XOR compression and plane collection for the
// 3-share null-fresh chi layer. Optional build macro: NF_CF_REG_CLEAR_EN (precharge cf register).
module nf_chi_compress #(
  parameter int ROWS  = 5,
  parameter int CNT_W = 6
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [44:0]         cf_in,
  input  logic                in_valid,
  output logic                in_ready,
  output logic [5*ROWS-1:0]   plane_s1,
  output logic [5*ROWS-1:0]   plane_s2,
  output logic [5*ROWS-1:0]   plane_s3,
  output logic                out_valid,
  input  logic                out_ready,
  output logic                busy
);

  typedef enum logic [1:0] {
    FILL  = 2'd0,
    DRAIN = 2'd1,
    HOLD  = 2'd2
  } state_t;

  state_t             state_r;
  state_t             state_s;
  logic [44:0]        cf_r;
  logic               stage_valid_r;
  logic [CNT_W-1:0]   row_r;
  logic [CNT_W-1:0]   acc_r;
  logic [CNT_W-1:0]   acc_s;
  logic               in_ready_r;
  logic               in_ready_s;
  logic               out_valid_r;
  logic               out_valid_s;
  logic               busy_r;
  logic               busy_s;
  logic               accept_s;
  logic               row_clear_s;
  logic [5*ROWS-1:0]  plane_s1_r;
  logic [5*ROWS-1:0]  plane_s2_r;
  logic [5*ROWS-1:0]  plane_s3_r;
  logic [4:0]         sh1_s;
  logic [4:0]         sh2_s;
  logic [4:0]         sh3_s;

  // Each output bit of share s is the XOR of its own three component functions only.
  function automatic logic [4:0] share_bits(input logic [44:0] cf, input int s);
    logic [4:0] r;
    r = 5'd0;
    for (int g = 0; g < 5; g++) begin
      r[g] = cf[9*g + 3*s] ^ cf[9*g + 3*s + 1] ^ cf[9*g + 3*s + 2];
    end
    return r;
  endfunction

  assign accept_s = in_valid && in_ready_r;
  assign sh1_s    = share_bits(cf_r, 0);
  assign sh2_s    = share_bits(cf_r, 1);
  assign sh3_s    = share_bits(cf_r, 2);

  // Next-state, accepted-row count and registered handshake outputs.
  always_comb begin
    state_s     = state_r;
    acc_s       = acc_r;
    in_ready_s  = 1'b0;
    out_valid_s = 1'b0;
    row_clear_s = 1'b0;
    case (state_r)
      FILL: begin
        if (accept_s) begin
          acc_s = acc_r + CNT_W'(1);
        end else begin
          acc_s = acc_r;
        end
        if (acc_s == CNT_W'(ROWS)) begin
          state_s    = DRAIN;
          in_ready_s = 1'b0;
        end else begin
          in_ready_s = 1'b1;
        end
      end
      DRAIN: begin
        state_s     = HOLD;
        out_valid_s = 1'b1;
      end
      HOLD: begin
        if (out_valid_r && out_ready) begin
          state_s     = FILL;
          acc_s       = {CNT_W{1'b0}};
          row_clear_s = 1'b1;
          in_ready_s  = 1'b1;
        end else begin
          out_valid_s = 1'b1;
        end
      end
      default: begin
        state_s = FILL;
        acc_s   = {CNT_W{1'b0}};
      end
    endcase
    busy_s = (state_s != FILL) || accept_s || (acc_s != {CNT_W{1'b0}});
  end

  // Control state and registered handshake outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= FILL;
      acc_r       <= {CNT_W{1'b0}};
      in_ready_r  <= 1'b0;
      out_valid_r <= 1'b0;
      busy_r      <= 1'b0;
    end else begin
      state_r     <= state_s;
      acc_r       <= acc_s;
      in_ready_r  <= in_ready_s;
      out_valid_r <= out_valid_s;
      busy_r      <= busy_s;
    end
  end

  // Glitch barrier: cf_in goes straight into the register with no logic in front.
  always_ff @(posedge clk) begin
    if (rst) begin
      cf_r          <= 45'd0;
      stage_valid_r <= 1'b0;
    end else begin
      stage_valid_r <= accept_s;
      if (accept_s) begin
        cf_r <= cf_in;
      end else begin
`ifdef NF_CF_REG_CLEAR_EN
        cf_r <= 45'd0;
`else
        cf_r <= cf_r;
`endif
      end
    end
  end

  // Row write pointer; cleared when a completed plane is handed off.
  always_ff @(posedge clk) begin
    if (rst) begin
      row_r <= {CNT_W{1'b0}};
    end else if (row_clear_s) begin
      row_r <= {CNT_W{1'b0}};
    end else if (stage_valid_r) begin
      row_r <= row_r + CNT_W'(1);
    end else begin
      row_r <= row_r;
    end
  end

  // Plane buffer: old contents are overwritten row by row, never bulk-cleared.
  always_ff @(posedge clk) begin
    if (rst) begin
      plane_s1_r <= {(5*ROWS){1'b0}};
      plane_s2_r <= {(5*ROWS){1'b0}};
      plane_s3_r <= {(5*ROWS){1'b0}};
    end else if (stage_valid_r) begin
      for (int r = 0; r < ROWS; r++) begin
        if (row_r == CNT_W'(r)) begin
          plane_s1_r[5*r +: 5] <= sh1_s;
          plane_s2_r[5*r +: 5] <= sh2_s;
          plane_s3_r[5*r +: 5] <= sh3_s;
        end
      end
    end
  end

  assign in_ready  = in_ready_r;
  assign out_valid = out_valid_r;
  assign busy      = busy_r;
  assign plane_s1  = plane_s1_r;
  assign plane_s2  = plane_s2_r;
  assign plane_s3  = plane_s3_r;

endmodule

// File: tb/tb_nf_chi_compress.sv
// Directed self-checking bench for nf_chi_compress (ROWS=5).
module tb_nf_chi_compress;

  localparam int ROWS = 5;
  localparam logic [44:0] ALL1 = 45'h1FFF_FFFF_FFFF;
`ifdef NF_CF_REG_CLEAR_EN
  localparam logic [44:0] IDLE_CF = 45'h0;
`else
  localparam logic [44:0] IDLE_CF = 45'h123;
`endif

  logic              clk = 1'b0;
  logic              rst;
  logic [44:0]       cf_in;
  logic              in_valid;
  logic              in_ready;
  logic [5*ROWS-1:0] plane_s1;
  logic [5*ROWS-1:0] plane_s2;
  logic [5*ROWS-1:0] plane_s3;
  logic              out_valid;
  logic              out_ready;
  logic              busy;

  int tests_run = 0;
  int tests_failed = 0;
  logic [44:0] rows [5];

  nf_chi_compress #(.ROWS(ROWS), .CNT_W(6)) dut (
    .clk(clk), .rst(rst), .cf_in(cf_in), .in_valid(in_valid), .in_ready(in_ready),
    .plane_s1(plane_s1), .plane_s2(plane_s2), .plane_s3(plane_s3),
    .out_valid(out_valid), .out_ready(out_ready), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Five back-to-back rows from rows[]; returns in the cycle after the last accept.
  task automatic send_plane();
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1;
      cf_in = rows[i];
      tick();
    end
    in_valid = 1'b0;
    cf_in = 45'd0;
  endtask

  task automatic release_plane();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; cf_in = 45'd0;
    tick(); tick();
    tests_run++; if (in_ready !== 1'b0) begin tests_failed++; $display("FAIL reset_in_ready: got %b want 0", in_ready); end
    tests_run++; if (out_valid !== 1'b0) begin tests_failed++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
    tests_run++; if (busy !== 1'b0) begin tests_failed++; $display("FAIL reset_busy: got %b want 0", busy); end
    tests_run++; if ((plane_s1 | plane_s2 | plane_s3) !== 25'd0) begin tests_failed++; $display("FAIL reset_planes: got %h/%h/%h want 0", plane_s1, plane_s2, plane_s3); end
    rst = 1'b0;
    tick();
    tests_run++; if (in_ready !== 1'b1) begin tests_failed++; $display("FAIL reset_release_in_ready: got %b want 1", in_ready); end
  endtask

  task automatic test_all_ones();
    for (int i = 0; i < 5; i++) rows[i] = ALL1;
    send_plane();
    tests_run++; if (in_ready !== 1'b0 || out_valid !== 1'b0 || busy !== 1'b1) begin tests_failed++; $display("FAIL ones_drain: got rdy=%b vld=%b busy=%b want 0 0 1", in_ready, out_valid, busy); end
    tick();
    tests_run++; if (out_valid !== 1'b1) begin tests_failed++; $display("FAIL ones_out_valid: got %b want 1", out_valid); end
    tests_run++; if (plane_s1 !== 25'h1FFFFFF || plane_s2 !== 25'h1FFFFFF || plane_s3 !== 25'h1FFFFFF) begin tests_failed++; $display("FAIL ones_planes: got %h/%h/%h want 1ffffff", plane_s1, plane_s2, plane_s3); end
    release_plane();
    tests_run++; if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0) begin tests_failed++; $display("FAIL ones_release: got rdy=%b vld=%b busy=%b want 1 0 0", in_ready, out_valid, busy); end
  endtask

  task automatic test_cf0();
    rows[0] = 45'h1; rows[1] = 45'h0; rows[2] = 45'h0; rows[3] = 45'h0; rows[4] = 45'h0;
    send_plane();
    tick();
    tests_run++; if (plane_s1 !== 25'h0000001 || plane_s2 !== 25'h0 || plane_s3 !== 25'h0) begin tests_failed++; $display("FAIL cf0_planes: got %h/%h/%h want 0000001/0/0", plane_s1, plane_s2, plane_s3); end
    release_plane();
  endtask

  task automatic test_row2_triple();
    rows[0] = 45'h0; rows[1] = 45'h0; rows[2] = 45'hE00; rows[3] = 45'h0; rows[4] = 45'h0;
    send_plane();
    tick();
    tests_run++; if (plane_s1 !== 25'h0000800 || plane_s2 !== 25'h0 || plane_s3 !== 25'h0) begin tests_failed++; $display("FAIL row2_planes: got %h/%h/%h want 0000800/0/0", plane_s1, plane_s2, plane_s3); end
  endtask

  // Entered with a completed plane (s1=0x800) waiting in HOLD.
  task automatic test_hold();
    in_valid = 1'b1; cf_in = ALL1;
    for (int i = 0; i < 10; i++) begin
      tick();
      tests_run++; if (in_ready !== 1'b0 || out_valid !== 1'b1 || plane_s1 !== 25'h800 || plane_s2 !== 25'h0) begin tests_failed++; $display("FAIL hold_stable[%0d]: got rdy=%b vld=%b s1=%h s2=%h want 0 1 800 0", i, in_ready, out_valid, plane_s1, plane_s2); end
    end
    release_plane();
    tests_run++; if (in_ready !== 1'b1 || out_valid !== 1'b0 || plane_s1 !== 25'h800) begin tests_failed++; $display("FAIL hold_release: got rdy=%b vld=%b s1=%h want 1 0 800", in_ready, out_valid, plane_s1); end
    cf_in = 45'h1;
    tick();
    in_valid = 1'b0;
    tick();
    tests_run++; if (plane_s1 !== 25'h801) begin tests_failed++; $display("FAIL hold_new_row0: got %h want 801", plane_s1); end
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1; cf_in = 45'h0;
      tick();
    end
    in_valid = 1'b0;
    tick(); tick();
    tests_run++; if (out_valid !== 1'b1 || plane_s1 !== 25'h1) begin tests_failed++; $display("FAIL hold_second_plane: got vld=%b s1=%h want 1 0000001", out_valid, plane_s1); end
    release_plane();
  endtask

  task automatic test_shares_gaps();
    rows[0] = 45'h0; rows[1] = 45'h58; rows[2] = 45'h0; rows[3] = 45'h0; rows[4] = 45'h7000;
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1; cf_in = rows[i];
      tick();
      in_valid = 1'b0; cf_in = ALL1;
      tick();
      if (i == 3) begin
        tests_run++; if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b1) begin tests_failed++; $display("FAIL gaps_partial: got rdy=%b vld=%b busy=%b want 1 0 1", in_ready, out_valid, busy); end
      end
    end
    tick();
    tests_run++; if (out_valid !== 1'b1) begin tests_failed++; $display("FAIL gaps_out_valid: got %b want 1", out_valid); end
    tests_run++; if (plane_s1 !== 25'h0 || plane_s2 !== 25'h200000 || plane_s3 !== 25'h20) begin tests_failed++; $display("FAIL gaps_planes: got %h/%h/%h want 0/200000/20", plane_s1, plane_s2, plane_s3); end
    cf_in = 45'h0;
    release_plane();
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1; cf_in = ALL1;
      tick();
    end
    in_valid = 1'b0;
    rst = 1'b1;
    tick();
    tests_run++; if (busy !== 1'b0 || in_ready !== 1'b0 || dut.row_r !== 6'd0) begin tests_failed++; $display("FAIL midrst_ctrl: got busy=%b rdy=%b row=%0d want 0 0 0", busy, in_ready, dut.row_r); end
    tests_run++; if ((plane_s1 | plane_s2 | plane_s3) !== 25'd0) begin tests_failed++; $display("FAIL midrst_planes: got %h/%h/%h want 0", plane_s1, plane_s2, plane_s3); end
    rst = 1'b0;
    tick();
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1; cf_in = ALL1;
      tick();
    end
    in_valid = 1'b0;
    tick(); tick();
    tests_run++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin tests_failed++; $display("FAIL midrst_four: got rdy=%b vld=%b want 1 0", in_ready, out_valid); end
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tests_run++; if (in_ready !== 1'b0) begin tests_failed++; $display("FAIL midrst_fifth_rdy: got %b want 0", in_ready); end
    tick(); tick();
    tests_run++; if (out_valid !== 1'b1 || plane_s1 !== 25'h1FFFFFF || plane_s3 !== 25'h1FFFFFF) begin tests_failed++; $display("FAIL midrst_complete: got vld=%b s1=%h s3=%h want 1 1ffffff 1ffffff", out_valid, plane_s1, plane_s3); end
    out_ready = 1'b1; rst = 1'b1;
    tick();
    tests_run++; if (out_valid !== 1'b0 || in_ready !== 1'b0 || busy !== 1'b0 || plane_s2 !== 25'd0) begin tests_failed++; $display("FAIL holdrst: got vld=%b rdy=%b busy=%b s2=%h want 0 0 0 0", out_valid, in_ready, busy, plane_s2); end
    out_ready = 1'b0; rst = 1'b0;
    tick();
  endtask

  task automatic test_cf_clear();
    in_valid = 1'b1; cf_in = 45'h123;
    tick();
    tests_run++; if (dut.cf_r !== 45'h123) begin tests_failed++; $display("FAIL cfreg_first: got %h want 123", dut.cf_r); end
    in_valid = 1'b0; cf_in = 45'h456;
    tick();
    tests_run++; if (dut.cf_r !== IDLE_CF) begin tests_failed++; $display("FAIL cfreg_idle: got %h want %h", dut.cf_r, IDLE_CF); end
    in_valid = 1'b1; cf_in = 45'h789;
    tick();
    in_valid = 1'b0;
    tests_run++; if (dut.cf_r !== 45'h789) begin tests_failed++; $display("FAIL cfreg_second: got %h want 789", dut.cf_r); end
  endtask

  initial begin
    test_reset();
    test_all_ones();
    test_cf0();
    test_row2_triple();
    test_hold();
    test_shares_gaps();
    test_reset_mid();
    test_cf_clear();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
